// File: rtl/mips_regfile.sv
// 32-entry MIPS general-purpose register file: two bypassed read ports, a raw debug port,
// a hardwired $zero and a saturating count of committed writes.
module mips_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          BYPASS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_we,
    input  logic [ADDR_WIDTH-1:0] in_waddr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic [ADDR_WIDTH-1:0] in_raddr1,
    input  logic [ADDR_WIDTH-1:0] in_raddr2,
    input  logic [ADDR_WIDTH-1:0] in_dbg_addr,
    output logic [DATA_WIDTH-1:0] out_rdata1,
    output logic [DATA_WIDTH-1:0] out_rdata2,
    output logic [DATA_WIDTH-1:0] out_dbg_data,
    output logic [15:0]           out_wr_count
);

    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [CNT_W-1:0]      r_wr_count;

    logic w_commit;
    logic w_byp1;
    logic w_byp2;

    // A write commits only outside reset and never to $zero
    assign w_commit = rst_n && in_we && (in_waddr != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else begin
            if (w_commit) begin
                r_regs[in_waddr] <= in_wdata;
            end
            if (w_commit && (r_wr_count != CNT_MAX)) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    assign w_byp1 = BYPASS_EN && w_commit && (in_waddr == in_raddr1);
    assign w_byp2 = BYPASS_EN && w_commit && (in_waddr == in_raddr2);

    // Address 0 reads as zero on every port; bypass forwards the in-flight write
    always_comb begin
        out_rdata1   = '0;
        out_rdata2   = '0;
        out_dbg_data = '0;
        if (in_raddr1 != '0) begin
            out_rdata1 = w_byp1 ? in_wdata : r_regs[in_raddr1];
        end
        if (in_raddr2 != '0) begin
            out_rdata2 = w_byp2 ? in_wdata : r_regs[in_raddr2];
        end
        if (in_dbg_addr != '0) begin
            out_dbg_data = r_regs[in_dbg_addr];
        end
    end

    assign out_wr_count = r_wr_count;

endmodule

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- 32-entry general-purpose register file for the MIPS datapath.
- It is the consumer end of the 5-bit destination-register select path: it takes the selected write address (rt or rd), write data and write enable from write-back, and serves two source operands (rs, rt) to decode.
- Provides a same-cycle write-to-read bypass and a hardwired $zero.
- Provides a read-only debug port for the bench and for the board display.

Parameters:
DATA_WIDTH, 32, width of each register in bits
ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH (32)
BYPASS_EN, 1, 1 = a read of the register being written this cycle returns the write data; 0 = it returns the old contents

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_we  input  1  write enable from write-back stage
in_waddr  input  ADDR_WIDTH  destination register (output of 5-bit dest mux)
in_wdata  input  DATA_WIDTH  write-back data
in_raddr1  input  ADDR_WIDTH  source register rs
in_raddr2  input  ADDR_WIDTH  source register rt
in_dbg_addr  input  ADDR_WIDTH  debug read address
out_rdata1  output  DATA_WIDTH  rs operand
out_rdata2  output  DATA_WIDTH  rt operand
out_dbg_data  output  DATA_WIDTH  debug read data (no bypass)
out_wr_count  output  16  count of committed writes to non-zero registers since reset, saturating

Behaviour:
Interface:
- One clock domain (clk); reset is synchronous and active-low (rst_n).
- All state changes occur on the rising edge of clk.

Reset:
- Sampled on a rising edge of clk while rst_n = 0.
- Clears all 32 registers to 0 and out_wr_count to 0 in that single edge.
- Writes presented in the same cycle as reset are discarded.
- Read outputs are combinational from storage, so after the reset edge every read returns 0.

Reset mid-operation:
- Asserting reset between writes discards all stored contents.
- No partial state is retained.

Write:
- On a rising edge with rst_n = 1, in_we = 1 and in_waddr != 0: register[in_waddr] <= in_wdata.
- The new value is visible via storage from the next cycle.
- in_we = 0: no change.

$zero:
- Register 0 is never written; in_we = 1 with in_waddr = 0 is ignored.
- Any read of address 0 returns 0 on every port, including while a write to address 0 is presented.

Read ports 1 and 2:
- Combinational, zero latency.
- out_rdataN = 0 if in_raddrN == 0.
- Otherwise, if BYPASS_EN and in_we and in_waddr == in_raddrN and rst_n: out_rdataN = in_wdata.
- Otherwise: out_rdataN = register[in_raddrN].
- Both ports may address the same register; each returns the same value.
- Bypass is suppressed while rst_n = 0.

Debug port:
- Combinational read of storage only; never bypassed.
- Returns 0 for address 0.

out_wr_count:
- Increments by 1 on each edge that commits a write (in_we = 1, in_waddr != 0, rst_n = 1).
- Saturates at 16'hFFFF; no wrap-around.
- Writes of identical data still count.
- A write of 0 to a register still counts.

Back-to-back writes:
- Writes to the same register on consecutive cycles: the last write wins.
- Each committed write counts.

X handling:
- With in_we = 0, in_waddr and in_wdata are don't-care and must not affect state or outputs.

Test Plan:
- Reset then read all: hold rst_n = 0 for 1 edge; sweep in_raddr1/in_raddr2/in_dbg_addr over 0..31 -> every output 0; out_wr_count = 0.
- Write/readback: write 32'hDEADBEEF to r8, 32'h0000_1234 to r31; next cycle read r8 on port 1 and r31 on port 2 -> DEADBEEF / 00001234; out_wr_count = 2.
- $zero protection: in_we = 1, in_waddr = 0, in_wdata = 32'hFFFFFFFF, in_raddr1 = 0 in the same cycle and the next -> out_rdata1 = 0 both cycles; out_dbg_data(0) = 0; out_wr_count unchanged.
- Bypass: r5 holds 32'h11; in the same cycle write r5 = 32'h22 with in_raddr1 = in_raddr2 = 5 -> both read ports = 32'h22 while out_dbg_data(5) = 32'h11; next cycle all = 32'h22. With BYPASS_EN = 0 -> ports read 32'h11 in the write cycle.
- Reset mid-operation: write r3 = 32'hA5A5A5A5, then assert rst_n = 0 in the same cycle as a write of r4 = 32'h5 -> after the edge r3 = 0, r4 = 0, out_wr_count = 0; no bypass of r4 during reset.
- Counter saturation: force 70000 committed writes (cycling r1..r31) -> out_wr_count holds 16'hFFFF with no wrap; a subsequent write still updates storage.
